bp_wormhole_to_burst: RTL and testbench
=======================================

// Module: bp_wormhole_to_burst
// PURPOSE
//  Receive end of a wormhole link: deserializes a flit stream into BedRock Burst (one header beat,
//  zero or more data beats). Sits after the wormhole router/concentrator, feeding the Burst consumer.
//  Packet layout: header flits (wormhole cord|len|cid + protocol header, LSB first), then data flits.
//  Header flits carry no data; every data flit belongs to a data beat.
// PARAMETERS
//  flit_width_p     "inv"  link flit width
//  cord_width_p     0      destination {y,x} coord width (LSBs of first flit)
//  len_width_p      "inv"  len field width; at bits [cord_width_p +: len_width_p] of first flit
//  cid_width_p      0      concentrator id width
//  pr_hdr_width_p   "inv"  protocol header width
//  pr_data_width_p  "inv"  Burst data beat width; integer multiple of flit_width_p
//  hdr_width_p      cord+len+cid+pr_hdr  total header width; integer multiple of flit_width_p
// PORTS
//  clk_i               in   1                clock
//  reset_i             in   1                sync active-high reset
//  link_data_i         in   flit_width_p     wormhole flit
//  link_v_i            in   1                flit valid
//  link_ready_and_o    out  1                flit accept (ready&valid)
//  pr_hdr_o            out  hdr_width_p      assembled header, flit0 in LSBs
//  pr_hdr_v_o          out  1                header valid
//  pr_hdr_ready_and_i  in   1                header accept
//  pr_has_data_o       out  1                message has >=1 data beat; valid with pr_hdr_v_o
//  pr_data_o           out  pr_data_width_p  data beat, first flit in LSBs
//  pr_data_v_o         out  1                data valid
//  pr_data_ready_and_i in   1                data accept
//  pr_last_data_o      out  1                final data beat; valid with pr_data_v_o
// BEHAVIOUR
//  - hdr_len = hdr_width_p/flit_width_p; beat_len = pr_data_width_p/flit_width_p.
//  - len field = total flits in packet minus 1. data_flits = len+1-hdr_len; must be a multiple of beat_len.
//  - Flit accepted iff link_v_i & link_ready_and_o. Burst beat transfers iff v & ready_and.
//  - FSM: HDR_COLLECT -> HDR_SEND -> (DATA_COLLECT <-> DATA_SEND) -> HDR_COLLECT.
//  - HDR_COLLECT: link_ready_and_o=1; flit k stored at pr_hdr_o[k*flit_width_p+:flit_width_p];
//    len latched from flit 0 into data-flit down-counter. After flit hdr_len-1 -> HDR_SEND.
//  - HDR_SEND: pr_hdr_v_o=1 (registered; first valid cycle after last header flit), link_ready_and_o=0.
//    pr_has_data_o=(data_flits!=0). On accept: has_data ? DATA_COLLECT : HDR_COLLECT.
//  - DATA_COLLECT: link_ready_and_o=1; fills beat buffer LSB-first; after beat_len flits -> DATA_SEND.
//  - DATA_SEND: pr_data_v_o=1, link_ready_and_o=0; pr_last_data_o=1 iff remaining data flits==0.
//    On accept: last ? HDR_COLLECT : DATA_COLLECT.
//  - Data never valid before its header is accepted; header/data valid never both 1.
//  - Header-only (len=hdr_len-1) and hdr_len=1/beat_len=1 cases legal; no extra bubbles beyond FSM.
//  - Throughput: one output beat per (flits+1) cycles; no combinational link->Burst paths.
//  - Outputs held stable while v=1 and not accepted.
//  - Counters: flit idx log2(max(hdr_len,beat_len)) bits; remaining counter len_width_p bits, never wraps.
//  - Reset (any cycle, mid-packet included): state=HDR_COLLECT, counters=0, partial data discarded;
//    pr_hdr_v_o=0, pr_data_v_o=0, pr_has_data_o=0, pr_last_data_o=0, pr_hdr_o=0, pr_data_o=0;
//    link_ready_and_o=0 during reset, 1 first cycle after.
//  - Sim-only $fatal: width non-multiples; assertion: len<hdr_len-1 or data_flits%beat_len!=0.
// TESTING (flit 64, hdr_width 128 -> hdr_len 2, pr_data 128 -> beat_len 2)
//  1 Header-only: flits {len=1,A},{B} -> pr_hdr_o={B,A}, has_data=0, no data beat.
//  2 Two beats: len=5, flits H0,H1,D0..D3 -> hdr, then data {D1,D0} last=0, {D3,D2} last=1.
//  3 Backpressure: hold pr_hdr_ready_and_i=0 10 cycles -> link_ready_and_o=0, pr_hdr_o stable.
//  4 Link bubbles: link_v_i toggling 1/0 -> identical Burst output to case 2.
//  5 Reset after D0 accepted -> all valids 0; next packet (case 1) decoded cleanly.
//  6 Back-to-back 200 random packets vs scoreboard -> exact match, last on final beat only.

Source files
------------

// File: rtl/bp_wormhole_to_burst_if.sv
// Wormhole-link input and BedRock Burst output bundle for bp_wormhole_to_burst.
// master: the deserializer itself; slave: the link source / Burst consumer side.
interface bp_wormhole_to_burst_if #(
  parameter int unsigned flit_width_p    = 64,
  parameter int unsigned hdr_width_p     = 128,
  parameter int unsigned pr_data_width_p = 128
);
  logic [flit_width_p-1:0]    link_data_i;
  logic                       link_v_i;
  logic                       link_ready_and_o;
  logic [hdr_width_p-1:0]     pr_hdr_o;
  logic                       pr_hdr_v_o;
  logic                       pr_hdr_ready_and_i;
  logic                       pr_has_data_o;
  logic [pr_data_width_p-1:0] pr_data_o;
  logic                       pr_data_v_o;
  logic                       pr_data_ready_and_i;
  logic                       pr_last_data_o;

  modport master (
    input  link_data_i, link_v_i, pr_hdr_ready_and_i, pr_data_ready_and_i,
    output link_ready_and_o, pr_hdr_o, pr_hdr_v_o, pr_has_data_o,
           pr_data_o, pr_data_v_o, pr_last_data_o
  );

  modport slave (
    output link_data_i, link_v_i, pr_hdr_ready_and_i, pr_data_ready_and_i,
    input  link_ready_and_o, pr_hdr_o, pr_hdr_v_o, pr_has_data_o,
           pr_data_o, pr_data_v_o, pr_last_data_o
  );
endinterface

// File: rtl/bp_wormhole_to_burst.sv
// Wormhole receive endpoint: deserializes header flits then data flits into one
// Burst header beat followed by zero or more data beats.
module bp_wormhole_to_burst #(
  parameter int unsigned flit_width_p    = 64,
  parameter int unsigned cord_width_p    = 0,
  parameter int unsigned len_width_p     = 8,
  parameter int unsigned cid_width_p     = 0,
  parameter int unsigned pr_hdr_width_p  = 120,
  parameter int unsigned pr_data_width_p = 128,
  parameter int unsigned hdr_width_p     = cord_width_p + len_width_p + cid_width_p + pr_hdr_width_p
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bp_wormhole_to_burst_if.master bus
);

  localparam int unsigned hdr_len_lp   = hdr_width_p / flit_width_p;
  localparam int unsigned beat_len_lp  = pr_data_width_p / flit_width_p;
  localparam int unsigned max_len_lp   = (hdr_len_lp > beat_len_lp) ? hdr_len_lp : beat_len_lp;
  localparam int unsigned idx_width_lp = (max_len_lp > 1) ? $clog2(max_len_lp) : 1;

  typedef enum logic [1:0] {
    e_hdr_collect  = 2'd0,
    e_hdr_send     = 2'd1,
    e_data_collect = 2'd2,
    e_data_send    = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [idx_width_lp-1:0]    idx_q, idx_d;
  logic [len_width_p-1:0]     rem_q, rem_d;
  logic [hdr_width_p-1:0]     hdr_q, hdr_d;
  logic [pr_data_width_p-1:0] data_q, data_d;
  logic                       has_data_q, has_data_d;
  logic                       last_q, last_d;

  logic                       link_ready;
  logic                       link_accept;
  logic [len_width_p-1:0]     len_field;

  // Ready depends only on the collect states; reset forces it low in the same cycle.
  assign link_ready  = ~reset_i & ((state_q == e_hdr_collect) | (state_q == e_data_collect));
  assign link_accept = bus.link_v_i & link_ready;
  assign len_field   = bus.link_data_i[cord_width_p +: len_width_p];

  assign bus.link_ready_and_o = link_ready;
  assign bus.pr_hdr_o         = hdr_q;
  assign bus.pr_hdr_v_o       = (state_q == e_hdr_send);
  assign bus.pr_has_data_o    = has_data_q;
  assign bus.pr_data_o        = data_q;
  assign bus.pr_data_v_o      = (state_q == e_data_send);
  assign bus.pr_last_data_o   = last_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= e_hdr_collect;
      idx_q      <= '0;
      rem_q      <= '0;
      hdr_q      <= '0;
      data_q     <= '0;
      has_data_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      hdr_q      <= hdr_d;
      data_q     <= data_d;
      has_data_q <= has_data_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    hdr_d      = hdr_q;
    data_d     = data_q;
    has_data_d = has_data_q;
    last_d     = last_q;

    unique case (state_q)
      e_hdr_collect: begin
        if (link_accept) begin
          for (int k = 0; k < int'(hdr_len_lp); k++) begin
            if (idx_q == idx_width_lp'(k)) hdr_d[k*flit_width_p +: flit_width_p] = bus.link_data_i;
          end
          // len counts every flit minus one; keep only the data flits still to come
          if (idx_q == '0) rem_d = len_field - len_width_p'(hdr_len_lp - 1);
          if (idx_q == idx_width_lp'(hdr_len_lp - 1)) begin
            state_d    = e_hdr_send;
            idx_d      = '0;
            has_data_d = (rem_d != '0);
          end else begin
            idx_d = idx_q + idx_width_lp'(1);
          end
        end
      end

      e_hdr_send: begin
        if (bus.pr_hdr_ready_and_i) begin
          state_d    = has_data_q ? e_data_collect : e_hdr_collect;
          has_data_d = 1'b0;
        end
      end

      e_data_collect: begin
        if (link_accept) begin
          for (int k = 0; k < int'(beat_len_lp); k++) begin
            if (idx_q == idx_width_lp'(k)) data_d[k*flit_width_p +: flit_width_p] = bus.link_data_i;
          end
          if (rem_q != '0) rem_d = rem_q - len_width_p'(1);
          if (idx_q == idx_width_lp'(beat_len_lp - 1)) begin
            state_d = e_data_send;
            idx_d   = '0;
            last_d  = (rem_d == '0);
          end else begin
            idx_d = idx_q + idx_width_lp'(1);
          end
        end
      end

      e_data_send: begin
        if (bus.pr_data_ready_and_i) begin
          state_d = last_q ? e_hdr_collect : e_data_collect;
          last_d  = 1'b0;
        end
      end

      default: state_d = e_hdr_collect;
    endcase
  end

`ifndef SYNTHESIS
  // Guard against illegal geometry and malformed len fields.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ((hdr_width_p % flit_width_p == 0) && (pr_data_width_p % flit_width_p == 0))
        else $fatal(1, "bp_wormhole_to_burst: widths are not flit multiples");
      if ((state_q == e_hdr_collect) && link_accept && (idx_q == '0)) begin
        assert (32'(len_field) >= hdr_len_lp - 1)
          else $error("bp_wormhole_to_burst: len shorter than header");
        assert (((32'(len_field) + 1 - hdr_len_lp) % beat_len_lp) == 0)
          else $error("bp_wormhole_to_burst: data flits not a beat multiple");
      end
    end
  end
`endif

endmodule

// File: tb/tb_bp_wormhole_to_burst.sv
// Directed and random bench for bp_wormhole_to_burst: packet-level model plus
// per-cycle output compare and literal expectations for the named cases.
module tb_bp_wormhole_to_burst;
  localparam int unsigned FW  = 64;
  localparam int unsigned LW  = 8;
  localparam int unsigned PHW = 120;
  localparam int unsigned HW  = 128;
  localparam int unsigned PDW = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_wormhole_to_burst_if #(.flit_width_p(FW), .hdr_width_p(HW), .pr_data_width_p(PDW)) bus ();

  bp_wormhole_to_burst #(
    .flit_width_p(FW), .cord_width_p(0), .len_width_p(LW), .cid_width_p(0),
    .pr_hdr_width_p(PHW), .pr_data_width_p(PDW)
  ) dut (
    .clk_i(clk), .reset_i(reset), .bus(bus)
  );

  typedef struct {
    bit           is_hdr;
    logic [127:0] pay;
    bit           flag;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  mode     = 0;   // 0: always ready, 1: random ready, 2: header held off

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected Burst transactions for one packet, straight from the len field.
  function automatic void model_packet(input logic [63:0] p[$]);
    ev_t e;
    int  data_flits, nbeats;
    data_flits = int'(p[0][7:0]) + 1 - 2;
    nbeats     = data_flits / 2;
    e.is_hdr = 1'b1; e.pay = {p[1], p[0]}; e.flag = (data_flits != 0);
    exp_q.push_back(e);
    for (int b = 0; b < nbeats; b++) begin
      e.is_hdr = 1'b0; e.pay = {p[3+2*b], p[2+2*b]}; e.flag = (b == nbeats - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic drive_flit(input logic [63:0] f);
    int t;
    @(negedge clk);
    bus.link_data_i = f;
    bus.link_v_i    = 1'b1;
    t = 0;
    while (!bus.link_ready_and_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.link_ready_and_o) chk("link_timeout", bus.link_ready_and_o, 1'b1);
    @(posedge clk);
  endtask

  // bub: 0 none, 1 bubble before every flit after the first, 2 random bubbles
  task automatic drive_packet(input logic [63:0] p[$], input int bub, input bit idle_after);
    foreach (p[i]) begin
      if ((bub == 1 && i > 0) || (bub == 2 && $urandom_range(0, 3) == 0)) begin
        @(negedge clk);
        bus.link_v_i = 1'b0;
      end
      drive_flit(p[i]);
    end
    if (idle_after) begin
      @(negedge clk);
      bus.link_v_i = 1'b0;
    end
  endtask

  task automatic wait_hdr();
    int t = 0;
    do begin @(negedge clk); #2; t++; end while (!bus.pr_hdr_v_o && t < 100);
    if (!bus.pr_hdr_v_o) chk("hdr_timeout", bus.pr_hdr_v_o, 1'b1);
  endtask

  task automatic wait_data();
    int t = 0;
    do begin @(negedge clk); #2; t++; end while (!bus.pr_data_v_o && t < 100);
    if (!bus.pr_data_v_o) chk("data_timeout", bus.pr_data_v_o, 1'b1);
  endtask

  always @(negedge clk) begin
    case (mode)
      1:       begin bus.pr_hdr_ready_and_i = ($urandom_range(0, 9) < 7); bus.pr_data_ready_and_i = ($urandom_range(0, 9) < 7); end
      2:       begin bus.pr_hdr_ready_and_i = 1'b0; bus.pr_data_ready_and_i = 1'b1; end
      default: begin bus.pr_hdr_ready_and_i = 1'b1; bus.pr_data_ready_and_i = 1'b1; end
    endcase
  end

  // Per-cycle compare against the model queue, plus hold-while-stalled checks.
  bit           stall_h = 0, stall_d = 0, p_hd = 0, p_last = 0;
  logic [127:0] p_hdr = '0, p_data = '0;
  initial begin
    ev_t e;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        stall_h = 0; stall_d = 0;
      end else begin
        if (bus.pr_hdr_v_o && bus.pr_data_v_o) chk("both_valid", 1'b1, 1'b0);
        if (stall_h) begin
          chk("hdr_hold_v", bus.pr_hdr_v_o, 1'b1);
          chk("hdr_hold", {bus.pr_has_data_o, bus.pr_hdr_o}, {p_hd, p_hdr});
        end
        if (stall_d) begin
          chk("data_hold_v", bus.pr_data_v_o, 1'b1);
          chk("data_hold", {bus.pr_last_data_o, bus.pr_data_o}, {p_last, p_data});
        end
        if (bus.pr_hdr_v_o && bus.pr_hdr_ready_and_i) begin
          if (exp_q.size() == 0) chk("hdr_unexpected", bus.pr_hdr_v_o, 1'b0);
          else begin
            e = exp_q.pop_front();
            chk("order_hdr", e.is_hdr, 1'b1);
            chk("hdr", bus.pr_hdr_o, e.pay);
            chk("has_data", bus.pr_has_data_o, e.flag);
          end
        end
        if (bus.pr_data_v_o && bus.pr_data_ready_and_i) begin
          if (exp_q.size() == 0) chk("data_unexpected", bus.pr_data_v_o, 1'b0);
          else begin
            e = exp_q.pop_front();
            chk("order_data", e.is_hdr, 1'b0);
            chk("data", bus.pr_data_o, e.pay);
            chk("last", bus.pr_last_data_o, e.flag);
          end
        end
        stall_h = bus.pr_hdr_v_o && !bus.pr_hdr_ready_and_i;
        stall_d = bus.pr_data_v_o && !bus.pr_data_ready_and_i;
        p_hdr = bus.pr_hdr_o; p_hd = bus.pr_has_data_o;
        p_data = bus.pr_data_o; p_last = bus.pr_last_data_o;
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_hdr_v", bus.pr_hdr_v_o, 1'b0);
    chk("rst_data_v", bus.pr_data_v_o, 1'b0);
    chk("rst_has_data", bus.pr_has_data_o, 1'b0);
    chk("rst_last", bus.pr_last_data_o, 1'b0);
    chk("rst_hdr", bus.pr_hdr_o, '0);
    chk("rst_data", bus.pr_data_o, '0);
    chk("rst_link_ready", bus.link_ready_and_o, 1'b0);
  endtask

  task automatic run_two_beat(input int bub);
    logic [63:0] p[$];
    p = '{64'h0123_4567_89AB_CD05, 64'hFEDC_BA98_7654_3210, 64'hD0D0_0000_0000_0D00,
          64'hD1D1_1111_1111_1D11, 64'hD2D2_2222_2222_2D22, 64'hD3D3_3333_3333_3D33};
    model_packet(p);
    fork
      drive_packet(p, bub, 1'b1);
      begin
        wait_hdr();
        chk("c2_hdr", bus.pr_hdr_o, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CD05);
        chk("c2_has_data", bus.pr_has_data_o, 1'b1);
        wait_data();
        chk("c2_beat0", bus.pr_data_o, 128'hD1D1_1111_1111_1D11_D0D0_0000_0000_0D00);
        chk("c2_last0", bus.pr_last_data_o, 1'b0);
        wait_data();
        chk("c2_beat1", bus.pr_data_o, 128'hD3D3_3333_3333_3D33_D2D2_2222_2222_2D22);
        chk("c2_last1", bus.pr_last_data_o, 1'b1);
      end
    join
  endtask

  task automatic run_hdr_only();
    logic [63:0] p[$];
    p = '{64'h1122_3344_5566_7701, 64'hAABB_CCDD_EEFF_0011};
    model_packet(p);
    fork
      drive_packet(p, 0, 1'b1);
      begin
        wait_hdr();
        chk("c1_hdr", bus.pr_hdr_o, 128'hAABB_CCDD_EEFF_0011_1122_3344_5566_7701);
        chk("c1_has_data", bus.pr_has_data_o, 1'b0);
      end
    join
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [63:0] p[$];
    reset = 1'b1;
    bus.link_data_i = '0;
    bus.link_v_i    = 1'b0;
    bus.pr_hdr_ready_and_i  = 1'b1;
    bus.pr_data_ready_and_i = 1'b1;
    repeat (3) @(negedge clk);
    #2 chk_reset_outputs();
    @(negedge clk) reset = 1'b0;
    #2 chk("post_rst_link_ready", bus.link_ready_and_o, 1'b1);

    run_hdr_only();
    run_two_beat(0);

    // Header backpressure: link stalls, header stays put.
    mode = 2;
    @(negedge clk);
    p = '{64'h5555_6666_7777_8801, 64'h9999_AAAA_BBBB_CCCC};
    model_packet(p);
    fork
      drive_packet(p, 0, 1'b1);
      begin
        wait_hdr();
        repeat (10) begin
          @(negedge clk); #2;
          chk("c3_link_ready", bus.link_ready_and_o, 1'b0);
          chk("c3_hdr", bus.pr_hdr_o, 128'h9999_AAAA_BBBB_CCCC_5555_6666_7777_8801);
        end
        mode = 0;
      end
    join
    repeat (4) @(negedge clk);

    run_two_beat(1);

    // Reset after the first data flit: partial beat discarded.
    p = '{64'h0000_0000_0000_0005, 64'h1, 64'hDEAD_BEEF_0000_0001};
    model_packet(p);
    drive_flit(p[0]);
    drive_flit(p[1]);
    drive_flit(p[2]);
    @(negedge clk);
    bus.link_v_i = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk); #2 chk_reset_outputs();
    @(negedge clk) reset = 1'b0;
    #2 chk("c5_link_ready", bus.link_ready_and_o, 1'b1);
    chk("c5_hdr_v", bus.pr_hdr_v_o, 1'b0);
    run_hdr_only();

    // Back-to-back random packets with random bubbles and backpressure.
    mode = 1;
    for (int n = 0; n < 200; n++) begin
      int nb;
      nb = $urandom_range(0, 3);
      p.delete();
      p.push_back({$urandom(), 24'($urandom()), LW'(1 + 2 * nb)});
      p.push_back({$urandom(), $urandom()});
      for (int f = 0; f < 2 * nb; f++) p.push_back({$urandom(), $urandom()});
      model_packet(p);
      drive_packet(p, 2, n == 199);
    end
    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    end
    chk("drain", 128'(exp_q.size()), '0);
    mode = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
